button_pulse_gen: RTL

//  Input conditioner for the two game push-buttons (move, select). It is the producing end of the

---
 rtl/button_pulse_gen.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/button_pulse_gen.sv
// Push-button conditioner: synchronises and debounces the active-low move/select pads and
// turns each accepted press into a one-cycle pulse; move auto-repeats while held.

module button_pulse_chan #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 8,
  parameter int REPEAT_EN       = 1,
  parameter int CW              = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pad_n,
  output logic       fire,
  output logic       level,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    RELEASING = 3'd0,
    IDLE      = 3'd1,
    ARMING    = 3'd2,
    HELD      = 3'd3,
    REPEAT    = 3'd4
  } state_t;

  localparam logic [CW:0] DB_L = (CW+1)'(DEBOUNCE_CYCLES);
  localparam logic [CW:0] RD_L = (CW+1)'(REPEAT_DELAY);
  localparam logic [CW:0] RP_L = (CW+1)'(REPEAT_PERIOD);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW:0]     inc;
  logic            sync1;
  logic            sync2;
  logic            pressed;

  assign pressed   = ~sync2;
  assign inc       = {1'b0, cnt} + 1'b1;
  assign state_dbg = state;

  // fire marks the edge on which this channel emits a pulse; the top registers it.
  always_comb begin
    fire = 1'b0;
    case (state)
      IDLE:    fire = pressed && (DEBOUNCE_CYCLES == 1);
      ARMING:  fire = pressed && (inc >= DB_L);
      HELD:    fire = pressed && (REPEAT_EN != 0) && (inc >= RD_L);
      REPEAT:  fire = pressed && (inc >= RP_L);
      default: fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      state <= RELEASING;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= pad_n;
      sync2 <= sync1;
      case (state)
        RELEASING: begin
          if (pressed) begin
            cnt <= '0;
          end else if (inc >= DB_L) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
          end else begin
            cnt <= inc[CW-1:0];
          end
        end
        IDLE: begin
          if (pressed) begin
            if (fire) begin
              state <= HELD;
              cnt   <= '0;
              level <= 1'b1;
            end else begin
              state <= ARMING;
              cnt   <= CW'(1);
            end
          end
        end
        ARMING: begin
          if (!pressed) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (fire) begin
            state <= HELD;
            cnt   <= '0;
            level <= 1'b1;
          end else begin
            cnt <= inc[CW-1:0];
          end
        end
        HELD, REPEAT: begin
          // The release sample itself counts as the first stable released cycle.
          if (!pressed) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state <= IDLE;
              cnt   <= '0;
              level <= 1'b0;
            end else begin
              state <= RELEASING;
              cnt   <= CW'(1);
            end
          end else if (fire) begin
            state <= REPEAT;
            cnt   <= '0;
          end else if ((REPEAT_EN != 0) || (state == REPEAT)) begin
            cnt <= inc[CW-1:0];
          end
        end
        default: begin
          state <= RELEASING;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

module button_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_n,
  input  logic       select_n,
  output logic       move_pulse,
  output logic       select_pulse,
  output logic       move_level,
  output logic       select_level,
  output logic [5:0] state_dbg
);

  localparam int MAXV = (DEBOUNCE_CYCLES > REPEAT_DELAY)
                      ? ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
                      : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam int CW   = $clog2(MAXV + 1);

  logic       move_fire;
  logic       select_fire;
  logic [2:0] move_state;
  logic [2:0] select_state;

  assign state_dbg = {select_state, move_state};

  button_pulse_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (REPEAT_EN),
    .CW              (CW)
  ) u_move (
    .clk       (clk),
    .rst       (rst),
    .pad_n     (move_n),
    .fire      (move_fire),
    .level     (move_level),
    .state_dbg (move_state)
  );

  button_pulse_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (0),
    .CW              (CW)
  ) u_select (
    .clk       (clk),
    .rst       (rst),
    .pad_n     (select_n),
    .fire      (select_fire),
    .level     (select_level),
    .state_dbg (select_state)
  );

  // A colliding move pulse is dropped outright; the move FSM still advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      move_pulse   <= 1'b0;
      select_pulse <= 1'b0;
    end else begin
      move_pulse   <= move_fire & ~select_fire;
      select_pulse <= select_fire;
    end
  end

endmodule
